// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word width, NOP encoding, reset PC default and the IF/ID payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
  } ifid_t;

  typedef enum logic [0:0] {
    StFetch,
    StHalt
  } fetch_state_e;

  // Word index of the byte address must lie below the memory depth.
  function automatic logic pc_in_range(input logic [WORD_W-1:0] pc,
                                       input int unsigned       words);
    return ({2'b00, pc[WORD_W-1:2]} < words);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; flush keeps the pc fields.
module if_id_reg
  import mips_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_load,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;
  ifid_t w_d;

  always_comb begin
    w_d = r_q;
    if (i_flush) begin
      w_d.valid = 1'b0;
      w_d.instr = NOP_INSTR;
    end else if (i_load) begin
      w_d = i_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, range check, halt FSM,
// sticky error flags and fetch counter feeding the IF/ID register.
module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned       IMEM_WORDS = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic [WORD_W-1:0] imem_instr_i,
  output logic              ifid_valid_o,
  output logic [WORD_W-1:0] ifid_instr_o,
  output logic [WORD_W-1:0] ifid_pc_o,
  output logic [WORD_W-1:0] ifid_pc_plus4_o,
  output logic              misalign_o,
  output logic              oob_o,
  output logic [WORD_W-1:0] fetch_count_o
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_d;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_d;
  logic              r_misalign;
  logic              r_oob;
  logic [WORD_W-1:0] r_fetch_count;

  logic              w_halted;
  logic              w_in_range;
  logic [WORD_W-1:0] w_pc_plus4;
  logic              w_load;
  logic              w_flush;
  logic              w_count_inc;
  logic              w_oob_set;
  logic              w_misalign_set;
  ifid_t             w_ifid_d;
  ifid_t             w_ifid_q;

  assign w_in_range = pc_in_range(r_pc, IMEM_WORDS);
  assign w_pc_plus4 = r_pc + 32'd4;

  // Halt FSM: state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Halt FSM: next state. Stall masks the range check, so halting needs a non-stalled edge.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StFetch: begin
        if (!redirect_i && !stall_i && !w_in_range) begin
          w_state_d = StHalt;
        end
      end
      StHalt: begin
        if (redirect_i) begin
          w_state_d = StFetch;
        end
      end
      default: w_state_d = StFetch;
    endcase
  end

  // Halt FSM: outputs.
  always_comb begin
    w_halted = 1'b0;
    unique case (r_state)
      StFetch: w_halted = 1'b0;
      StHalt:  w_halted = 1'b1;
      default: w_halted = 1'b0;
    endcase
  end

  // Edge priority: redirect > halt > stall > sequential.
  always_comb begin
    w_pc_d         = r_pc;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    w_count_inc    = 1'b0;
    w_oob_set      = 1'b0;
    w_misalign_set = 1'b0;
    if (redirect_i) begin
      w_pc_d         = {redirect_pc_i[WORD_W-1:2], 2'b00};
      w_flush        = 1'b1;
      w_misalign_set = (redirect_pc_i[1:0] != 2'b00);
    end else if (w_halted) begin
      w_flush = 1'b1;
    end else if (stall_i) begin
      w_pc_d = r_pc;
    end else if (w_in_range) begin
      w_pc_d      = w_pc_plus4;
      w_load      = 1'b1;
      w_count_inc = 1'b1;
    end else begin
      w_flush   = 1'b1;
      w_oob_set = 1'b1;
    end
  end

  always_comb begin
    w_ifid_d.valid    = 1'b1;
    w_ifid_d.instr    = imem_instr_i;
    w_ifid_d.pc       = r_pc;
    w_ifid_d.pc_plus4 = w_pc_plus4;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc          <= RESET_PC;
      r_misalign    <= 1'b0;
      r_oob         <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc <= w_pc_d;
      if (w_misalign_set) begin
        r_misalign <= 1'b1;
      end
      if (w_oob_set) begin
        r_oob <= 1'b1;
      end
      if (w_count_inc) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem_addr_o     = r_pc;
  assign ifid_valid_o    = w_ifid_q.valid;
  assign ifid_instr_o    = w_ifid_q.instr;
  assign ifid_pc_o       = w_ifid_q.pc;
  assign ifid_pc_plus4_o = w_ifid_q.pc_plus4;
  assign misalign_o      = r_misalign;
  assign oob_o           = r_oob;
  assign fetch_count_o   = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios then random stall/redirect/reset traffic,
// all outputs compared each cycle against a behavioural fetch model.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        misalign;
  logic        oob;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:31];

  int n_checks;
  int n_errors;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifpc4;
  logic        m_halt;
  logic        m_mis;
  logic        m_oob;
  logic [31:0] m_cnt;

  instr_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (32)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .imem_addr_o     (imem_addr),
    .imem_instr_i    (imem_instr),
    .ifid_valid_o    (ifid_valid),
    .ifid_instr_o    (ifid_instr),
    .ifid_pc_o       (ifid_pc),
    .ifid_pc_plus4_o (ifid_pc_plus4),
    .misalign_o      (misalign),
    .oob_o           (oob),
    .fetch_count_o   (fetch_count)
  );

  assign imem_instr = (imem_addr[31:7] == 25'd0) ? mem[imem_addr[6:2]] : 32'hBAD0_BAD0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_ifpc  = 32'h0;
    m_ifpc4 = 32'h0;
    m_halt  = 1'b0;
    m_mis   = 1'b0;
    m_oob   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] tgt);
    if (rd) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_halt  = 1'b0;
      if (tgt % 4 != 0) m_mis = 1'b1;
    end else if (m_halt) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
    end else if (st) begin
      // everything holds
    end else if (m_pc / 4 < 32) begin
      m_valid = 1'b1;
      m_instr = mem[m_pc/4];
      m_ifpc  = m_pc;
      m_ifpc4 = m_pc + 4;
      m_pc    = m_pc + 4;
      m_cnt   = m_cnt + 1;
    end else begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_halt  = 1'b1;
      m_oob   = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_addr"},  imem_addr,             m_pc);
    check({tag, "_valid"}, {31'd0, ifid_valid},   {31'd0, m_valid});
    check({tag, "_instr"}, ifid_instr,            m_instr);
    check({tag, "_pc"},    ifid_pc,               m_ifpc);
    check({tag, "_pc4"},   ifid_pc_plus4,         m_ifpc4);
    check({tag, "_mis"},   {31'd0, misalign},     {31'd0, m_mis});
    check({tag, "_oob"},   {31'd0, oob},          {31'd0, m_oob});
    check({tag, "_cnt"},   fetch_count,           m_cnt);
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    @(posedge clk);
    model_edge(st, rd, tgt);
    #1;
    check_all("step");
  endtask

  // Called 1 ns after an edge: reset lands between edges and releases before the next one.
  task automatic async_reset();
    stall    = 1'b0;
    redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    #1;
    check_all("reset");
    #2;
    rst_n = 1'b1;

    // Free run over words 0..3.
    step(0, 0, 0);
    check("free_w0", ifid_instr, 32'h2008_0001);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("free_pc3", ifid_pc, 32'd12);
    check("free_cnt", fetch_count, 32'd4);

    // Stall after the second fetch.
    async_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("stall_addr", imem_addr, 32'd8);
    check("stall_instr", ifid_instr, 32'h2009_0002);
    check("stall_pc", ifid_pc, 32'd4);
    check("stall_cnt", fetch_count, 32'd2);

    // Redirect under stall, then misaligned redirect.
    step(1, 1, 32'h14);
    check("rd_valid", {31'd0, ifid_valid}, 32'd0);
    check("rd_addr", imem_addr, 32'h14);
    step(0, 0, 0);
    check("rd_tgt_pc", ifid_pc, 32'h14);
    check("rd_tgt_instr", ifid_instr, mem[5]);
    step(0, 1, 32'h17);
    check("mis_addr", imem_addr, 32'h14);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    step(0, 1, 32'h0);
    check("mis_sticky", {31'd0, misalign}, 32'd1);

    // Run off the end of memory, then recover via redirect.
    step(0, 1, 32'h70);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check("oob_flag", {31'd0, oob}, 32'd1);
    check("oob_addr", imem_addr, 32'h80);
    check("oob_valid", {31'd0, ifid_valid}, 32'd0);
    step(1, 0, 0);
    step(0, 1, 32'h0);
    step(0, 0, 0);
    check("resume_valid", {31'd0, ifid_valid}, 32'd1);
    check("resume_pc", ifid_pc, 32'h0);
    check("resume_oob", {31'd0, oob}, 32'd1);

    // Mid-run asynchronous reset.
    async_reset();
    step(0, 0, 0);
    check("rst_restart_pc", ifid_pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset();
      end else begin
        step($urandom_range(0, 3) == 0, r < 12, 32'($urandom_range(0, 159)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage of the MIPS core: holds the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for the decoder. Supports hazard stalls from the hazard unit and PC redirects (taken branch/jump) from later stages. A redirect squashes the in-flight fetch. Out-of-range fetches halt the stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `IMEM_WORDS`, 32, instruction-memory depth in 32-bit words; fetch range check
- `clk_i` in 1, rising-edge clock
- `rst_n_i` in 1, asynchronous active-low reset
- `stall_i` in 1, hold PC and IF/ID contents
- `redirect_i` in 1, load new PC and squash the current fetch
- `redirect_pc_i` in 32, redirect target
- `imem_addr_o` out 32, byte address to instruction memory; always equals the PC register
- `imem_instr_i` in 32, word read combinationally at `imem_addr_o`
- `ifid_valid_o` out 1, IF/ID holds a real instruction
- `ifid_instr_o` out 32, latched instruction; 32'h0 (NOP) whenever invalid
- `ifid_pc_o` out 32, address of the latched instruction
- `ifid_pc_plus4_o` out 32, `ifid_pc_o` + 4
- `misalign_o` out 1, sticky: a redirect target had bits [1:0] ≠ 0
- `oob_o` out 1, sticky: a fetch address fell outside the memory
- `fetch_count_o` out 32, count of valid instructions latched into IF/ID

## Operation
- **Reset (asynchronous, `rst_n_i`=0):**
  - PC = `RESET_PC`.
  - `ifid_valid_o`=0, `ifid_instr_o`=0, `ifid_pc_o`=0, `ifid_pc_plus4_o`=0.
  - `misalign_o`=0, `oob_o`=0, `fetch_count_o`=0.
  - Internal halt flag cleared.
- **In range:** the PC is in range when (PC>>2) < `IMEM_WORDS`.
- **Priority at each rising edge: redirect > halt > stall > sequential.**
- **Redirect (`redirect_i`=1):**
  - PC ← {`redirect_pc_i`[31:2], 2'b00}.
  - IF/ID ← invalid, `ifid_instr_o`=0; the pc fields hold their previous values.
  - Halt flag cleared.
  - `misalign_o` set if `redirect_pc_i`[1:0] ≠ 0.
  - Applies even when `stall_i`=1.
- **Halt (flag set, no redirect):** PC holds; IF/ID is written invalid/NOP.
- **Stall (`stall_i`=1, no redirect):**
  - PC, IF/ID and `fetch_count_o` all hold.
  - The halt flag is not evaluated.
- **Sequential (no stall, no redirect, not halted):**
  - If the PC is in range:
    - IF/ID ← {valid=1, `imem_instr_i`, PC, PC+4}.
    - PC ← PC+4, wrapping mod 2^32.
    - `fetch_count_o` +1, wrapping mod 2^32.
  - If the PC is out of range:
    - IF/ID ← invalid/NOP.
    - PC holds.
    - Halt flag set; `oob_o` set.
- `misalign_o` and `oob_o` clear only on reset.

## Timing
- Instruction-memory read is combinational: `imem_instr_i` for `imem_addr_o` is sampled on the same edge.
- Fetch-to-IF/ID latency is 1 cycle.
- First valid `ifid_*` appears one edge after reset release, for address `RESET_PC`.
- Redirect penalty:
  - Redirect at edge N → the target address is on `imem_addr_o` after edge N.
  - Target instruction is valid in IF/ID after edge N+1.
  - Exactly one bubble.
- Stall held for k edges → IF/ID is unchanged for k cycles; the PC does not advance.
- Reset asserted mid-operation:
  - All registers return to reset values immediately, without waiting for a clock.
  - No partial update survives.

## Structure
- Shared package `mips_pkg` holds:
  - `WORD_W`=32
  - `NOP_INSTR`=32'h0
  - default `RESET_PC`
  - packed struct `ifid_t` {valid, instr, pc, pc_plus4}, reused by the decode stage
- One natural sub-module, `if_id_reg`: the pipeline register with load/flush/hold controls and asynchronous reset.
- The PC register, next-PC mux, range check, sticky flags and counter live in the top module.

## Test plan
- **Reset then free-run,** memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x0:
  - After edges 1..4, IF/ID shows those words with pc 0, 4, 8, 12 and valid=1.
  - `fetch_count_o`=4.
- **Stall for 3 cycles after the second fetch:**
  - `imem_addr_o` stays at 8; IF/ID holds 0x20090002/pc 4.
  - `fetch_count_o` stays at 2.
- **Redirect to 0x14 while `stall_i`=1:**
  - Next cycle: `ifid_valid_o`=0, `ifid_instr_o`=0, `imem_addr_o`=0x14.
  - Following edge: word 5 is valid with pc 0x14.
- **Redirect to 0x17:**
  - `imem_addr_o`=0x14 and `misalign_o`=1.
  - `misalign_o` stays 1 after further redirects until reset.
- **Sequential fetch to address 0x80 with `IMEM_WORDS`=32:**
  - `oob_o`=1 and the PC sticks at 0x80; IF/ID is invalid.
  - A redirect to 0x0 resumes fetching while `oob_o` remains 1.
- **Assert `rst_n_i` asynchronously between edges mid-run:**
  - All outputs reach reset values before the next edge.
  - After release, fetch restarts at `RESET_PC`.
